hsk_io_transmitter: RTL and testbench
=====================================

# hsk_io_transmitter

Peripheral-side transmitter for the processor's two-wire byte input port. It buffers bytes pushed by an external source in a small FIFO and presents them, one at a time, on the processor's `in` data lines using a four-phase req/ack handshake over `hsk_1` (request, driven here) and `hsk_2` (acknowledge, driven by the processor controller). It raises `external_interrupt` toward the MHVPIS while data is waiting, and flags stalled handshakes and dropped pushes.

## Interface
- `DATA_W`, 8, byte width on the processor port
- `DEPTH`, 4, FIFO entries; power of two, at least 2
- `TIMEOUT`, 255, cycles allowed in REQ without an acknowledge; at least 1
- `clk`  in  1  system clock, rising edge
- `clr`  in  1  reset, asynchronous, active-high
- `wr_en`  in  1  push `wr_data` into the FIFO
- `wr_data`  in  DATA_W  byte to enqueue
- `full`  out  1  FIFO holds DEPTH entries
- `count`  out  $clog2(DEPTH)+1  current FIFO occupancy
- `out_data`  out  DATA_W  byte presented to the processor `in`
- `hsk_1`  out  1  request: `out_data` valid
- `hsk_2`  in  1  acknowledge from the processor; synchronous to `clk`
- `external_interrupt`  out  1  data-pending interrupt to the MHVPIS
- `timeout_err`  out  1  sticky: a handshake timed out
- `overrun`  out  1  sticky: a push was dropped
- `err_clr`  in  1  clears both sticky flags

## Operation
- FSM states: IDLE, REQ, REL.
- IDLE: when `count != 0`, load the FIFO head into the `out_data` register and go to REQ. The head is not popped yet.
- REQ: `hsk_1` = 1.
  - `hsk_2` sampled 1: pop the head and go to REL.
  - Otherwise, after TIMEOUT consecutive REQ cycles: set `timeout_err` and go to IDLE without popping. The same byte is retried.
- REL: `hsk_1` = 0. Go to IDLE when `hsk_2` is sampled 0.
- `out_data` is held from REQ entry until the next REQ entry. It never changes while `hsk_1` = 1.
- Push rule:
  - A push is accepted when `full` = 0 in that cycle.
  - `wr_en` while `full` = 1 drops the byte and sets `overrun`, even if a pop occurs in the same cycle.
  - A simultaneous accepted push and pop leaves `count` unchanged.
- FIFO pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. `count` saturates at neither end, because pushes are gated by `full` and pops by the FSM.
- `err_clr` clears the sticky flags. If a flag's set condition occurs in the same cycle as `err_clr`, set wins.
- Reset: state IDLE, pointers 0, `count` 0, and `full`, `hsk_1`, `out_data`, `external_interrupt`, `timeout_err`, `overrun` all 0, plus the timeout counter 0. Reset mid-handshake drops `hsk_1` asynchronously and discards all buffered bytes.

## Timing
- All outputs are registered.
- Push-to-request latency with an idle FSM: push at edge N, `count` = 1 after N, `hsk_1` = 1 after N+1.
- `hsk_2` sampled high at edge K: `hsk_1` = 0 and `count` decremented after K.
- Minimum of 3 cycles per byte with an immediate ack/release: IDLE, REQ, REL.
- Timeout: `hsk_1` high for exactly TIMEOUT cycles, `timeout_err` = 1 after the last of them, then 1 IDLE cycle before REQ re-enters.
- `external_interrupt` follows `count != 0` with a one-register delay.

## Configuration
- `HSK_IRQ_EN`
  - Defined: `external_interrupt` = 1 while the FIFO is non-empty, registered.
  - Undefined: `external_interrupt` is tied to 0 and its logic is removed. The processor must then poll `hsk_1`.

## Structure
- Shared package `hsk_pkg`: FSM state enum (IDLE, REQ, REL) and default constants for DATA_W, DEPTH and TIMEOUT. The processor-side handshake receiver uses the same package.
- One sub-module: `hsk_fifo`, a parameterised synchronous FIFO with push/pop, `full`, `empty` and `count`. The top level holds the FSM, timeout counter, flags and interrupt.

## Test plan
- Reset: assert `clr` mid-REQ with 3 bytes queued. `hsk_1`, `count`, `out_data`, `external_interrupt`, `timeout_err` and `overrun` all go to 0 immediately, and the FSM stays IDLE after release.
- Single byte: push 0xA5, processor acks 2 cycles after `hsk_1` rises. `out_data` = 0xA5 is stable throughout, `hsk_1` falls the cycle after the ack, `count` goes 1→0, and `external_interrupt` deasserts (with `HSK_IRQ_EN`).
- Ordering/wrap: push 0x01..0x0A, with 4 accepted, then drain and refill over 3 rounds. Bytes are delivered in order across pointer wrap, and `overrun` = 1 after the 5th push of the first burst.
- Full with simultaneous pop: with `full` = 1, push 0x77 in the cycle `hsk_2` is sampled high. 0x77 is dropped, `overrun` = 1, and `count` = 3.
- Timeout: push 0x3C, hold `hsk_2` = 0 with TIMEOUT = 5. `hsk_1` is high for 5 cycles, `timeout_err` = 1, then 0x3C is re-requested. Ack it and `count` = 0. `err_clr` then clears `timeout_err`.
- Without `HSK_IRQ_EN`: repeat the single-byte scenario. `external_interrupt` stays 0 and the handshake is unchanged.

Source files
------------

// File: rtl/hsk_pkg.sv
// Shared definitions for the byte-port handshake transmitter and receiver:
// FSM state encoding and default geometry.
package hsk_pkg;

  localparam int HSK_DATA_W  = 8;
  localparam int HSK_DEPTH   = 4;
  localparam int HSK_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } hsk_state_t;

endpackage

// File: rtl/hsk_fifo.sv
// Synchronous FIFO with registered full/empty/count; pushes are ignored when
// full and pops when empty, so the occupancy never wraps.
module hsk_fifo
  import hsk_pkg::*;
#(
  parameter int W     = HSK_DATA_W,
  parameter int DEPTH = HSK_DEPTH
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_full;
  logic          r_empty;

  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count_nxt;

  assign w_push = push & ~r_full;
  assign w_pop  = pop & ~r_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = r_full;
  assign empty = r_empty;
  assign count = r_count;

endmodule

// File: rtl/hsk_io_transmitter.sv
// Buffers pushed bytes and offers them to the processor with a four-phase
// hsk_1/hsk_2 handshake. Define HSK_IRQ_EN for the data-pending interrupt.
module hsk_io_transmitter
  import hsk_pkg::*;
#(
  parameter int DATA_W  = HSK_DATA_W,
  parameter int DEPTH   = HSK_DEPTH,
  parameter int TIMEOUT = HSK_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic [DATA_W-1:0]      out_data,
  output logic                   hsk_1,
  input  logic                   hsk_2,
  output logic                   external_interrupt,
  output logic                   timeout_err,
  output logic                   overrun,
  input  logic                   err_clr,
  output hsk_state_t             dbg_state
);

  // Handshake: hsk_1 high means out_data is valid and held; the processor
  // raises hsk_2 to take it, and must drop hsk_2 before the next byte.
  localparam int TW = $clog2(TIMEOUT + 1);

  hsk_state_t              r_state;
  hsk_state_t              w_state_nxt;
  logic [TW-1:0]           r_tmo;
  logic [TW-1:0]           w_tmo_nxt;
  logic                    r_hsk_1;
  logic [DATA_W-1:0]       r_out_data;
  logic                    r_timeout_err;
  logic                    r_overrun;

  logic [DATA_W-1:0]       w_head;
  logic                    w_full;
  logic                    w_empty;
  logic [$clog2(DEPTH):0]  w_count;
  logic                    w_pop;
  logic                    w_load;
  logic                    w_timeout;
  logic                    w_drop;

  hsk_fifo #(
    .W     (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .clr   (clr),
    .push  (wr_en),
    .pop   (w_pop),
    .din   (wr_data),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  assign w_drop = wr_en & w_full;

  always_comb begin
    w_state_nxt = r_state;
    w_tmo_nxt   = '0;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_load      = 1'b1;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        if (hsk_2) begin
          w_pop       = 1'b1;
          w_state_nxt = REL;
        end else if (r_tmo == TW'(TIMEOUT - 1)) begin
          // Head stays in the FIFO so the same byte is offered again.
          w_timeout   = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_tmo_nxt = r_tmo + 1'b1;
        end
      end
      REL: begin
        if (!hsk_2) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state       <= IDLE;
      r_tmo         <= '0;
      r_hsk_1       <= 1'b0;
      r_out_data    <= '0;
      r_timeout_err <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tmo   <= w_tmo_nxt;
      r_hsk_1 <= (w_state_nxt == REQ);
      if (w_load) r_out_data <= w_head;
      // Set beats clear when both happen in one cycle.
      if (w_timeout)    r_timeout_err <= 1'b1;
      else if (err_clr) r_timeout_err <= 1'b0;
      if (w_drop)       r_overrun <= 1'b1;
      else if (err_clr) r_overrun <= 1'b0;
    end
  end

`ifdef HSK_IRQ_EN
  logic r_irq;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= ~w_empty;
    end
  end

  assign external_interrupt = r_irq;
`else
  assign external_interrupt = 1'b0;
`endif

  assign full        = w_full;
  assign count       = w_count;
  assign out_data    = r_out_data;
  assign hsk_1       = r_hsk_1;
  assign timeout_err = r_timeout_err;
  assign overrun     = r_overrun;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_hsk_io_transmitter.sv
// Bench for hsk_io_transmitter: directed scenarios plus a randomized run,
// checked against a byte-queue model of the FIFO and its sticky flags.
module tb_hsk_io_transmitter;
  import hsk_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int TMO   = 5;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef HSK_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          hsk_2 = 1'b0;
  logic          err_clr = 1'b0;
  logic          full;
  logic [CW-1:0] count;
  logic [DW-1:0] out_data;
  logic          hsk_1;
  logic          external_interrupt;
  logic          timeout_err;
  logic          overrun;
  hsk_state_t    dbg_state;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] exp_q[$];
  bit            m_overrun = 1'b0;
  bit            m_irq = 1'b0;
  bit            popped = 1'b0;
  logic [DW-1:0] pop_exp, pop_act;
  int            resp_wait = 0;

  hsk_io_transmitter #(.DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .clr(clr), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .count(count), .out_data(out_data), .hsk_1(hsk_1), .hsk_2(hsk_2),
    .external_interrupt(external_interrupt), .timeout_err(timeout_err),
    .overrun(overrun), .err_clr(err_clr), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // One clock: drive a push, step past the edge, update the reference model.
  task automatic cycle(input bit we, input logic [DW-1:0] wd);
    bit pre_req, pre_ack, was_full;
    logic [DW-1:0] pre_out;
    int prev_sz;
    wr_en = we; wr_data = wd;
    pre_req = hsk_1; pre_ack = hsk_2; pre_out = out_data;
    prev_sz = exp_q.size(); was_full = (prev_sz == DEPTH);
    @(posedge clk); #1;
    wr_en = 1'b0;
    popped = 1'b0;
    if (pre_req && pre_ack && exp_q.size() != 0) begin
      popped = 1'b1; pop_act = pre_out; pop_exp = exp_q.pop_front();
    end
    if (we && was_full) m_overrun = 1'b1;
    else begin
      if (err_clr) m_overrun = 1'b0;
      if (we) exp_q.push_back(wd);
    end
    m_irq = IRQ_ON && (prev_sz != 0);
  endtask

  // Processor-side responder: ack after a random 0..3 cycle delay, release on hsk_1 low.
  task automatic respond();
    if (hsk_1 && !hsk_2) begin
      if (resp_wait == 0) hsk_2 = 1'b1;
      else resp_wait--;
    end else if (!hsk_1 && hsk_2) begin
      hsk_2 = 1'b0; resp_wait = $urandom_range(0, 3);
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (hsk_1 !== 1'b0) begin n_bad++; $display("FAIL rst_hsk1 got=%b want=0", hsk_1); end
    n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL rst_count got=%0d want=0", count); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL rst_full got=%b want=0", full); end
    n_cmp++; if ({out_data, external_interrupt, timeout_err, overrun} !== '0) begin
      n_bad++; $display("FAIL rst_outs got=%h/%b/%b/%b want=0", out_data, external_interrupt, timeout_err, overrun);
    end
    clr = 1'b0;
    cycle(1'b1, 8'h11); cycle(1'b1, 8'h22); cycle(1'b1, 8'h33);
    n_cmp++; if (hsk_1 !== 1'b1) begin n_bad++; $display("FAIL rst_pre_req got=%b want=1", hsk_1); end
    #2 clr = 1'b1;
    #1;
    n_cmp++; if (hsk_1 !== 1'b0) begin n_bad++; $display("FAIL rst_async_hsk1 got=%b want=0", hsk_1); end
    n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL rst_async_count got=%0d want=0", count); end
    n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL rst_async_data got=%h want=00", out_data); end
    n_cmp++; if ({external_interrupt, timeout_err, overrun} !== 3'b000) begin
      n_bad++; $display("FAIL rst_async_flags got=%b%b%b want=000", external_interrupt, timeout_err, overrun);
    end
    exp_q.delete(); m_overrun = 1'b0; m_irq = 1'b0;
    @(posedge clk); #1;
    clr = 1'b0;
    repeat (4) begin
      cycle(1'b0, '0);
      n_cmp++; if (hsk_1 !== 1'b0 || dbg_state !== IDLE) begin
        n_bad++; $display("FAIL rst_stay_idle got hsk_1=%b state=%0d want 0/IDLE", hsk_1, dbg_state);
      end
      n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL rst_stay_count got=%0d want=0", count); end
    end
  endtask

  task automatic test_single_byte();
    cycle(1'b1, 8'hA5);
    n_cmp++; if (count !== CW'(1) || hsk_1 !== 1'b0) begin
      n_bad++; $display("FAIL single_push got count=%0d hsk_1=%b want 1/0", count, hsk_1);
    end
    n_cmp++; if (external_interrupt !== 1'b0) begin n_bad++; $display("FAIL single_irq0 got=%b want=0", external_interrupt); end
    cycle(1'b0, '0);
    n_cmp++; if (hsk_1 !== 1'b1 || out_data !== 8'hA5) begin
      n_bad++; $display("FAIL single_req got hsk_1=%b data=%h want 1/a5", hsk_1, out_data);
    end
    n_cmp++; if (external_interrupt !== IRQ_ON) begin n_bad++; $display("FAIL single_irq1 got=%b want=%b", external_interrupt, IRQ_ON); end
    cycle(1'b0, '0);
    n_cmp++; if (hsk_1 !== 1'b1 || out_data !== 8'hA5) begin
      n_bad++; $display("FAIL single_hold got hsk_1=%b data=%h want 1/a5", hsk_1, out_data);
    end
    hsk_2 = 1'b1;
    cycle(1'b0, '0);
    n_cmp++; if (hsk_1 !== 1'b0 || count !== '0) begin
      n_bad++; $display("FAIL single_ack got hsk_1=%b count=%0d want 0/0", hsk_1, count);
    end
    n_cmp++; if (!popped || pop_act !== 8'hA5) begin
      n_bad++; $display("FAIL single_data got popped=%b data=%h want 1/a5", popped, pop_act);
    end
    hsk_2 = 1'b0;
    cycle(1'b0, '0);
    n_cmp++; if (external_interrupt !== 1'b0 || hsk_1 !== 1'b0) begin
      n_bad++; $display("FAIL single_done got irq=%b hsk_1=%b want 0/0", external_interrupt, hsk_1);
    end
  endtask

  task automatic test_timeout();
    int hi;
    cycle(1'b1, 8'h3C);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, '0);
      if (hsk_1) hi++;
      else if (hi > 0) break;
    end
    n_cmp++; if (hi !== TMO) begin n_bad++; $display("FAIL tmo_len got=%0d want=%0d", hi, TMO); end
    n_cmp++; if (timeout_err !== 1'b1 || count !== CW'(1)) begin
      n_bad++; $display("FAIL tmo_flag got err=%b count=%0d want 1/1", timeout_err, count);
    end
    cycle(1'b0, '0);
    n_cmp++; if (hsk_1 !== 1'b1 || out_data !== 8'h3C) begin
      n_bad++; $display("FAIL tmo_retry got hsk_1=%b data=%h want 1/3c", hsk_1, out_data);
    end
    hsk_2 = 1'b1;
    cycle(1'b0, '0);
    n_cmp++; if (!popped || pop_act !== 8'h3C || count !== '0) begin
      n_bad++; $display("FAIL tmo_ack got popped=%b data=%h count=%0d want 1/3c/0", popped, pop_act, count);
    end
    hsk_2 = 1'b0;
    cycle(1'b0, '0);
    n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL tmo_sticky got=%b want=1", timeout_err); end
    err_clr = 1'b1; cycle(1'b0, '0); err_clr = 1'b0;
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL tmo_clear got=%b want=0", timeout_err); end
  endtask

  task automatic test_order_wrap();
    int n, c;
    err_clr = 1'b1; cycle(1'b0, '0); err_clr = 1'b0;
    for (int r = 0; r < 3; r++) begin
      n = (r == 0) ? 10 : $urandom_range(3, 6);
      for (int i = 0; i < n; i++) begin
        cycle(1'b1, (r == 0) ? DW'(i + 1) : DW'($urandom));
        if (r == 0 && i == 3) begin
          n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL wrap_ovr4 got=%b want=0", overrun); end
        end
        if (r == 0 && i == 4) begin
          n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL wrap_ovr5 got=%b want=1", overrun); end
        end
      end
      n_cmp++; if (count !== CW'(exp_q.size())) begin
        n_bad++; $display("FAIL wrap_fill r=%0d got=%0d want=%0d", r, count, exp_q.size());
      end
      resp_wait = 0; c = 0;
      while (c < 100 && (exp_q.size() != 0 || hsk_1 || hsk_2)) begin
        respond(); cycle(1'b0, '0); c++;
        if (popped) begin
          n_cmp++; if (pop_act !== pop_exp) begin n_bad++; $display("FAIL wrap_data r=%0d got=%h want=%h", r, pop_act, pop_exp); end
        end
      end
      n_cmp++; if (c >= 100 || count !== '0) begin
        n_bad++; $display("FAIL wrap_drain r=%0d cycles=%0d count=%0d want drained", r, c, count);
      end
    end
  endtask

  task automatic test_full_pop();
    int c;
    err_clr = 1'b1; cycle(1'b0, '0); err_clr = 1'b0;
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(8'h10 + i));
    n_cmp++; if (full !== 1'b1 || hsk_1 !== 1'b1) begin
      n_bad++; $display("FAIL fp_full got full=%b hsk_1=%b want 1/1", full, hsk_1);
    end
    hsk_2 = 1'b1;
    cycle(1'b1, 8'h77);
    n_cmp++; if (count !== CW'(3) || overrun !== 1'b1 || full !== 1'b0) begin
      n_bad++; $display("FAIL fp_drop got count=%0d ovr=%b full=%b want 3/1/0", count, overrun, full);
    end
    n_cmp++; if (!popped || pop_act !== 8'h10) begin n_bad++; $display("FAIL fp_pop got=%h want=10", pop_act); end
    hsk_2 = 1'b0; resp_wait = 0; c = 0;
    while (c < 100 && (exp_q.size() != 0 || hsk_1 || hsk_2)) begin
      respond(); cycle(1'b0, '0); c++;
      if (popped) begin
        n_cmp++; if (pop_act !== pop_exp) begin n_bad++; $display("FAIL fp_data got=%h want=%h", pop_act, pop_exp); end
      end
    end
    n_cmp++; if (c >= 100 || count !== '0) begin n_bad++; $display("FAIL fp_drain cycles=%0d count=%0d", c, count); end
  endtask

  task automatic test_random();
    bit pre_req;
    logic [DW-1:0] pre_out;
    int c;
    err_clr = 1'b1; cycle(1'b0, '0); err_clr = 1'b0;
    resp_wait = 0;
    for (int i = 0; i < 400; i++) begin
      respond();
      err_clr = ($urandom_range(0, 15) == 0);
      pre_req = hsk_1; pre_out = out_data;
      cycle(bit'($urandom_range(0, 1)), DW'($urandom));
      if (popped) begin
        n_cmp++; if (pop_act !== pop_exp) begin n_bad++; $display("FAIL rnd_data i=%0d got=%h want=%h", i, pop_act, pop_exp); end
      end
      n_cmp++; if (count !== CW'(exp_q.size()) || full !== (exp_q.size() == DEPTH)) begin
        n_bad++; $display("FAIL rnd_count i=%0d got=%0d/%b want=%0d", i, count, full, exp_q.size());
      end
      n_cmp++; if (overrun !== m_overrun || external_interrupt !== m_irq) begin
        n_bad++; $display("FAIL rnd_flags i=%0d got ovr=%b irq=%b want %b/%b", i, overrun, external_interrupt, m_overrun, m_irq);
      end
      if (pre_req && hsk_1) begin
        n_cmp++; if (out_data !== pre_out) begin n_bad++; $display("FAIL rnd_stable i=%0d got=%h want=%h", i, out_data, pre_out); end
      end
    end
    err_clr = 1'b0; c = 0;
    while (c < 100 && (exp_q.size() != 0 || hsk_1 || hsk_2)) begin
      respond(); cycle(1'b0, '0); c++;
      if (popped) begin
        n_cmp++; if (pop_act !== pop_exp) begin n_bad++; $display("FAIL rnd_tail got=%h want=%h", pop_act, pop_exp); end
      end
    end
    n_cmp++; if (c >= 100 || count !== '0) begin n_bad++; $display("FAIL rnd_drain cycles=%0d count=%0d", c, count); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_timeout();
    test_order_wrap();
    test_full_pop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
